// File: rtl/fifo8x9_ctrl.sv
// fifo8x9_ctrl -- sequencing controller for a small FIFO (8 words by default).
//
// Serialises held push/pop/clear requests into one-cycle storage and pointer
// strobes, and tracks the occupancy of the FIFO it drives.
//
// Ports
//   clk                 : single clock, rising edge
//   rst                 : asynchronous reset, active low
//   push, pop           : level requests, held by the requester until acked
//   clear               : synchronous flush request
//   wren, rden          : storage write / read enables
//   WrInc, RdInc        : pointer increment strobes (used as edges by the FIFO)
//   WrPtrClr, RdPtrClr  : pointer clear strobes
//   push_ack, pop_ack   : one-cycle completion pulses
//   full, empty         : occupancy flags, registered alongside count
//   count               : stored words, 0..DEPTH
//   overflow, underflow : sticky error flags, cleared by CLEAR or reset
module fifo8x9_ctrl #(
    parameter int Addr_width = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  clear,
    output logic                  wren,
    output logic                  rden,
    output logic                  WrInc,
    output logic                  RdInc,
    output logic                  WrPtrClr,
    output logic                  RdPtrClr,
    output logic                  push_ack,
    output logic                  pop_ack,
    output logic                  full,
    output logic                  empty,
    output logic [Addr_width:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                 DEPTH   = 1 << Addr_width;
    localparam logic [Addr_width:0] CNT_MAX = (Addr_width+1)'(DEPTH);
    localparam logic [Addr_width:0] CNT_ONE = (Addr_width+1)'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WINC  = 3'd2,
        READ  = 3'd3,
        RINC  = 3'd4,
        CLEAR = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [Addr_width:0]   count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  pri_q, pri_d;
    logic                  wren_q, wren_d;
    logic                  rden_q, rden_d;
    logic                  wrinc_q, wrinc_d;
    logic                  rdinc_q, rdinc_d;
    logic                  wrclr_q, wrclr_d;
    logic                  rdclr_q, rdclr_d;
    logic                  pack_q, pack_d;
    logic                  poack_q, poack_d;

    logic                  push_ok, pop_ok;
    logic                  go_write, go_read;
    logic [Addr_width:0]   count_inc, count_dec;

    // A request is only eligible when the FIFO can actually honour it.
    assign push_ok   = push && !full_q;
    assign pop_ok    = pop && !empty_q;
    assign count_inc = count_q + CNT_ONE;
    assign count_dec = count_q - CNT_ONE;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        full_d   = full_q;
        empty_d  = empty_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        pri_d    = pri_q;
        wren_d   = 1'b0;
        rden_d   = 1'b0;
        wrinc_d  = 1'b0;
        rdinc_d  = 1'b0;
        wrclr_d  = 1'b0;
        rdclr_d  = 1'b0;
        pack_d   = 1'b0;
        poack_d  = 1'b0;
        go_write = 1'b0;
        go_read  = 1'b0;

        case (state_q)
            IDLE: begin
                if (clear) begin
                    // Flush wins; any push/pop stays pending for a later IDLE.
                    state_d = CLEAR;
                    wrclr_d = 1'b1;
                    rdclr_d = 1'b1;
                end else begin
                    if (push && full_q)  ovf_d = 1'b1;
                    if (pop  && empty_q) udf_d = 1'b1;
                    if (push_ok && pop_ok) begin
                        // Contended: pri picks the winner and flips for fairness.
                        pri_d    = ~pri_q;
                        go_write = pri_q;
                        go_read  = ~pri_q;
                    end else begin
                        go_write = push_ok;
                        go_read  = pop_ok;
                    end
                    if (go_write) begin
                        state_d = WRITE;
                        wren_d  = 1'b1;
                    end else if (go_read) begin
                        state_d = READ;
                        rden_d  = 1'b1;
                    end
                end
            end
            WRITE: begin
                state_d = WINC;
                wrinc_d = 1'b1;
                pack_d  = 1'b1;
            end
            WINC: begin
                state_d = IDLE;
                count_d = count_inc;
                full_d  = (count_inc == CNT_MAX);
                empty_d = 1'b0;
            end
            READ: begin
                state_d = RINC;
                rdinc_d = 1'b1;
                poack_d = 1'b1;
            end
            RINC: begin
                state_d = IDLE;
                count_d = count_dec;
                full_d  = 1'b0;
                empty_d = (count_q == CNT_ONE);
            end
            CLEAR: begin
                state_d = IDLE;
                count_d = '0;
                full_d  = 1'b0;
                empty_d = 1'b1;
                ovf_d   = 1'b0;
                udf_d   = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered together with the state they belong to, so every
    // output is a flop output and WrInc/RdInc cannot glitch.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
            pri_q   <= 1'b0;
            wren_q  <= 1'b0;
            rden_q  <= 1'b0;
            wrinc_q <= 1'b0;
            rdinc_q <= 1'b0;
            wrclr_q <= 1'b0;
            rdclr_q <= 1'b0;
            pack_q  <= 1'b0;
            poack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
            pri_q   <= pri_d;
            wren_q  <= wren_d;
            rden_q  <= rden_d;
            wrinc_q <= wrinc_d;
            rdinc_q <= rdinc_d;
            wrclr_q <= wrclr_d;
            rdclr_q <= rdclr_d;
            pack_q  <= pack_d;
            poack_q <= poack_d;
        end
    end

    assign wren      = wren_q;
    assign rden      = rden_q;
    assign WrInc     = wrinc_q;
    assign RdInc     = rdinc_q;
    assign WrPtrClr  = wrclr_q;
    assign RdPtrClr  = rdclr_q;
    assign push_ack  = pack_q;
    assign pop_ack   = poack_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_fifo8x9_ctrl.sv
// Testbench for fifo8x9_ctrl: directed scenarios followed by randomized
// held-level push/pop/clear traffic with occasional resets. A transaction-level
// model schedules the strobes each accepted operation must produce.
module tb_fifo8x9_ctrl;

    localparam int DEPTH = 8;

    // Strobe bit positions: {wren,rden,WrInc,RdInc,WrPtrClr,RdPtrClr,push_ack,pop_ack}
    localparam logic [7:0] S_WREN = 8'h80;
    localparam logic [7:0] S_RDEN = 8'h40;
    localparam logic [7:0] S_WINC = 8'h20;
    localparam logic [7:0] S_RINC = 8'h10;
    localparam logic [7:0] S_WCLR = 8'h08;
    localparam logic [7:0] S_RCLR = 8'h04;
    localparam logic [7:0] S_PACK = 8'h02;
    localparam logic [7:0] S_OACK = 8'h01;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0, pop = 1'b0, clear = 1'b0;
    logic       wren, rden, WrInc, RdInc, WrPtrClr, RdPtrClr;
    logic       push_ack, pop_ack, full, empty, overflow, underflow;
    logic [3:0] count;

    int vectors = 0;
    int miscompares = 0;

    fifo8x9_ctrl #(.Addr_width(3)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .clear(clear),
        .wren(wren), .rden(rden), .WrInc(WrInc), .RdInc(RdInc),
        .WrPtrClr(WrPtrClr), .RdPtrClr(RdPtrClr),
        .push_ack(push_ack), .pop_ack(pop_ack),
        .full(full), .empty(empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // An accepted operation is a script of per-cycle strobe sets; the effect on
    // the word count lands with the last step (0 none, 1 +1, -1 -1, 2 flush).
    typedef struct {
        logic [7:0] stb;
        int         eff;
    } step_t;

    step_t      plan[$];
    step_t      cur;
    int         m_cnt = 0;
    bit         m_ovf = 0, m_udf = 0, m_pri = 0;
    logic [7:0] m_stb = 8'h00;
    bit         m_pe, m_oe, m_take_push;

    always @(negedge rst) begin
        plan.delete();
        m_cnt = 0;
        m_ovf = 0;
        m_udf = 0;
        m_pri = 0;
        m_stb = 8'h00;
    end

    always @(posedge clk) begin
        if (rst) begin
            if (plan.size() != 0) begin
                cur   = plan.pop_front();
                m_stb = cur.stb;
                if (cur.eff == 1)       m_cnt = m_cnt + 1;
                else if (cur.eff == -1) m_cnt = m_cnt - 1;
                else if (cur.eff == 2) begin
                    m_cnt = 0;
                    m_ovf = 0;
                    m_udf = 0;
                end
            end else begin
                m_stb = 8'h00;
                if (clear) begin
                    m_stb = S_WCLR | S_RCLR;
                    plan.push_back('{8'h00, 2});
                end else begin
                    if (push && m_cnt == DEPTH) m_ovf = 1;
                    if (pop && m_cnt == 0)      m_udf = 1;
                    m_pe = push && (m_cnt < DEPTH);
                    m_oe = pop && (m_cnt > 0);
                    if (m_pe && m_oe) begin
                        m_take_push = m_pri;
                        m_pri = !m_pri;
                    end else begin
                        m_take_push = m_pe;
                    end
                    if (m_take_push) begin
                        m_stb = S_WREN;
                        plan.push_back('{S_WINC | S_PACK, 0});
                        plan.push_back('{8'h00, 1});
                    end else if (m_oe) begin
                        m_stb = S_RDEN;
                        plan.push_back('{S_RINC | S_OACK, 0});
                        plan.push_back('{8'h00, -1});
                    end
                end
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    logic [15:0] dut_vec, exp_vec;
    always @(negedge clk) begin
        dut_vec = {wren, rden, WrInc, RdInc, WrPtrClr, RdPtrClr, push_ack, pop_ack,
                   count, full, empty, overflow, underflow};
        exp_vec = {m_stb, 4'(m_cnt), m_cnt == DEPTH, m_cnt == 0, m_ovf, m_udf};
        vectors++;
        if (dut_vec !== exp_vec) begin
            miscompares++;
            $display("FAIL model_cycle t=%0t: got %h expected %h (strobes|count|full|empty|ovf|udf)",
                     $time, dut_vec, exp_vec);
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Wait for the selected ack; n = negedges waited, prev = enable seen the cycle before.
    task automatic wait_ack(input bit is_push, input int maxc, output int n, output bit prev);
        bit got = 0;
        bit last_en = 0;
        n = 0;
        prev = 0;
        while (!got && n < maxc) begin
            @(negedge clk);
            n++;
            if (is_push ? push_ack : pop_ack) begin
                got  = 1;
                prev = last_en;
            end
            last_en = is_push ? wren : rden;
        end
        if (!got) begin
            miscompares++;
            vectors++;
            $display("FAIL ack_timeout: got no %s ack, required one within %0d cycles",
                     is_push ? "push" : "pop", maxc);
        end
    endtask

    task automatic do_reset();
        #1 rst = 1'b0;
        push = 1'b0;
        pop = 1'b0;
        clear = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
    endtask

    int  n, seq;
    bit  pw, bad;
    bit  pa, oa;

    initial begin
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs",
            {wren, rden, WrInc, RdInc, WrPtrClr, RdPtrClr, push_ack, pop_ack,
             count, full, empty, overflow, underflow}, 16'h0004);
        #1 rst = 1'b1;

        // Eight back-to-back held pushes, 3 cycles apart.
        push = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_ack(1'b1, 8, n, pw);
            chk("push_ack_spacing", n, (k == 0) ? 2 : 3);
            chk("wren_before_ack", pw, 1);
        end
        #1 push = 1'b0;
        @(negedge clk);
        chk("count_after_fill", count, 8);
        chk("full_after_fill", full, 1);
        chk("empty_after_fill", empty, 0);

        // Push while full.
        #1 push = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (wren || WrInc || push_ack) bad = 1;
        end
        chk("no_write_when_full", bad, 0);
        chk("overflow_set", overflow, 1);
        chk("count_stays_full", count, 8);
        #1 push = 1'b0;

        // Drain, then pop while empty, then flush.
        pop = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_ack(1'b0, 8, n, pw);
            chk("rden_before_ack", pw, 1);
        end
        #1 pop = 1'b0;
        @(negedge clk);
        chk("count_after_drain", count, 0);
        chk("empty_after_drain", empty, 1);
        #1 pop = 1'b1;
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (rden || RdInc || pop_ack) bad = 1;
        end
        chk("no_read_when_empty", bad, 0);
        chk("underflow_set", underflow, 1);
        chk("overflow_still_set", overflow, 1);
        #1 pop = 1'b0;
        clear = 1'b1;
        @(negedge clk);
        chk("ptr_clear_pair", {WrPtrClr, RdPtrClr}, 2'b11);
        #1 clear = 1'b0;
        @(negedge clk);
        chk("ptr_clear_one_cycle", {WrPtrClr, RdPtrClr}, 2'b00);
        chk("flags_after_clear", {overflow, underflow}, 2'b00);

        // Contention at count=3 right after reset: pop first, then push.
        do_reset();
        push = 1'b1;
        for (int k = 0; k < 3; k++) wait_ack(1'b1, 8, n, pw);
        #1 push = 1'b0;
        @(negedge clk);
        #1 push = 1'b1;
        pop = 1'b1;
        seq = 0;
        n = 0;
        while (push && n < 16) begin
            @(negedge clk);
            n++;
            pa = push_ack;
            oa = pop_ack;
            if (rden)  seq = seq * 10 + 1;
            if (RdInc) seq = seq * 10 + 2;
            if (wren)  seq = seq * 10 + 3;
            if (WrInc) seq = seq * 10 + 4;
            #1;
            if (oa) pop = 1'b0;
            if (pa) push = 1'b0;
        end
        chk("contention_strobe_order", seq, 1234);
        @(negedge clk);
        chk("count_after_contention", count, 3);

        // Reset during WRITE.
        do_reset();
        push = 1'b1;
        @(negedge clk);
        chk("wren_before_abort", wren, 1);
        #1 rst = 1'b0;
        push = 1'b0;
        bad = 0;
        repeat (2) begin
            @(negedge clk);
            if (WrInc || push_ack) bad = 1;
        end
        #1 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (WrInc || push_ack) bad = 1;
        end
        chk("no_ack_after_abort", bad, 0);
        chk("count_after_abort", count, 0);

        // Randomized traffic with alternating fill/drain bias.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            pa = push_ack;
            oa = pop_ack;
            #1;
            if (!rst) begin
                rst = 1'b1;
            end else if ($urandom_range(0, 499) == 0) begin
                rst = 1'b0;
            end
            clear = ($urandom_range(0, 79) == 0);
            if (push && pa)  push = ($urandom_range(0, 2) == 0);
            else if (!push)  push = ($urandom_range(0, 9) < (((i / 200) % 2 == 0) ? 6 : 2));
            else if ($urandom_range(0, 19) == 0) push = 1'b0;
            if (pop && oa)   pop = ($urandom_range(0, 2) == 0);
            else if (!pop)   pop = ($urandom_range(0, 9) < (((i / 200) % 2 == 0) ? 2 : 6));
            else if ($urandom_range(0, 19) == 0) pop = 1'b0;
        end
        #1 push = 1'b0;
        pop = 1'b0;
        clear = 1'b0;
        rst = 1'b1;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fifo8x9_ctrl.md
FIFO8X9_CTRL -- requirements
Module: fifo8x9_ctrl

Interface
REQ-001 The block SHALL have a parameter Addr_width, default 3, giving the FIFO address bits; depth DEPTH = 2**Addr_width.
REQ-002 The block SHALL have an input clk, 1 bit: the single clock, with all flops on its rising edge.
REQ-003 The block SHALL have an input rst, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have an input push, 1 bit: write request, level, held by the requester until push_ack.
REQ-005 The block SHALL have an input pop, 1 bit: read request, level, held by the requester until pop_ack.
REQ-006 The block SHALL have an input clear, 1 bit: synchronous flush request.
REQ-007 The block SHALL have outputs wren and rden, 1 bit each: FIFO storage write and read enables.
REQ-008 The block SHALL have outputs WrInc and RdInc, 1 bit each: FIFO pointer increment strobes, which the FIFO uses as edges.
REQ-009 The block SHALL have outputs WrPtrClr and RdPtrClr, 1 bit each: FIFO pointer clear strobes.
REQ-010 The block SHALL have outputs push_ack and pop_ack, 1 bit each: one-cycle completion pulses.
REQ-011 The block SHALL have outputs full and empty, 1 bit each: occupancy flags.
REQ-012 The block SHALL have an output count, Addr_width+1 bits: the number of stored words, 0..DEPTH.
REQ-013 The block SHALL have outputs overflow and underflow, 1 bit each: sticky error flags.

Function
REQ-014 The FSM SHALL have the states IDLE, WRITE, WINC, READ, RINC and CLEAR, and every state other than IDLE SHALL last exactly one cycle.
REQ-015 All strobe outputs SHALL come directly from flops (no combinational decode), so WrInc and RdInc are glitch-free.
REQ-016 In IDLE, requests SHALL be sampled in priority order: clear first, then push/pop arbitration.
REQ-017 clear=1 in IDLE SHALL move the FSM to CLEAR; other requests in the same cycle are ignored and stay pending.
REQ-018 In CLEAR, WrPtrClr=RdPtrClr=1 for one cycle, and on exit count=0, overflow=0 and underflow=0.
REQ-019 push=1 with full=0 (and push chosen by arbitration) SHALL sequence IDLE->WRITE->WINC->IDLE.
REQ-020 In WRITE, wren=1; in WINC, WrInc=1 and push_ack=1; count increments by 1 at the edge that ends WINC.
REQ-021 pop=1 with empty=0 (and pop chosen by arbitration) SHALL sequence IDLE->READ->RINC->IDLE.
REQ-022 In READ, rden=1; in RINC, RdInc=1 and pop_ack=1, and FIFO DataOut is valid from the RINC cycle onward.
REQ-023 count SHALL decrement by 1 at the edge that ends RINC.
REQ-024 When both push and pop are eligible, a priority bit pri SHALL decide which is serviced: pri=0 serves pop, pri=1 serves push.
REQ-025 pri SHALL toggle only when a contended cycle is arbitrated; pri resets to 0.
REQ-026 A push sampled in IDLE while full=1 SHALL set overflow=1, SHALL NOT leave IDLE and SHALL NOT ack; the pop path remains serviceable.
REQ-027 A pop sampled in IDLE while empty=1 SHALL set underflow=1, SHALL NOT leave IDLE and SHALL NOT ack.
REQ-028 overflow and underflow SHALL remain set until CLEAR or reset.
REQ-029 full SHALL equal (count==DEPTH) and empty SHALL equal (count==0), both registered and consistent with count in every cycle.
REQ-030 count SHALL never exceed DEPTH or go below 0; pointer wrap-around is left to the FIFO modulo DEPTH.
REQ-031 The minimum spacing between the starts of two operations SHALL be 3 cycles (IDLE, op, INC).
REQ-032 At most one of wren, rden, WrInc, RdInc or the clear pair SHALL be high in any cycle.

Reset
REQ-033 rst=0 SHALL immediately force state=IDLE, count=0, empty=1, full=0, pri=0, and every strobe, ack and error flag to 0.
REQ-034 Reset in the middle of an operation SHALL abandon that operation with no ack and no count change; the FIFO pointers are reset by the same rst.
REQ-035 After rst deasserts, the first request SHALL be sampled on the first rising clk edge.

Verification
REQ-036 Scenario: release reset -> empty=1, full=0, count=0, all strobes, acks and error flags 0.
REQ-037 Scenario: 8 back-to-back held pushes -> each completes in 3 cycles (wren at k+1, WrInc and push_ack at k+2); count ends at 8, full=1, empty=0.
REQ-038 Scenario: push while full (count=8) -> overflow=1, no wren or WrInc, count stays 8, push_ack never pulses.
REQ-039 Scenario: pop with count=0 -> underflow=1, no rden; then clear -> WrPtrClr=RdPtrClr=1 for one cycle, underflow=0.
REQ-040 Scenario: push and pop held together at count=3 after reset -> pop serviced first, then push; the strobe order is rden, RdInc, wren, WrInc; count returns to 3.
REQ-041 Scenario: rst asserted during the WRITE cycle -> WrInc never pulses, no push_ack, count=0 after reset.
